smb_frame_rx: RTL and testbench
===============================

# smb_frame_rx

Serial frame receiver directly upstream of the serial multi-broadcast switch. It watches a raw single-bit line and strips the start bit, the 4-bit port mask, the 2-bit nibble-count field and the stop bit. It then presents the payload bit-serially together with the port mask and current lane index, so the switch's serial input, lane select and port-mask inputs can be driven directly. It also flags framing errors.

## Interface
Parameters: none (field widths fixed in package).
- clk  in  1  rising-edge clock; one line bit per cycle
- rst_n  in  1  asynchronous, active-low reset
- line_in  in  1  raw serial line; idle level 1
- ser_out  out  1  payload bit, registered; feeds switch serial input
- ser_vld  out  1  ser_out holds a payload bit this cycle
- port_mask  out  4  destination mask from header, MSB first on line; held for the whole payload
- lane  out  2  index of current payload nibble (0..N)
- busy  out  1  frame in progress (any state other than IDLE)
- done  out  1  one-cycle pulse: frame ended with valid stop bit
- err  out  1  one-cycle pulse: stop bit sampled as 0

## Operation
- Frame on line_in, one bit per clk, in this order:
  - start bit 0
  - PB[3:0], MSB first
  - CNT[1:0], MSB first
  - payload of 4·(CNT+1) bits: nibble 0 first, each nibble MSB first
  - stop bit 1
- FSM states: IDLE, HDR_PB, HDR_CNT, PAYLOAD, STOP.
  - IDLE: line_in=0 → HDR_PB; otherwise stay.
  - HDR_PB: shift 4 bits into port_mask shadow; after 4th bit → HDR_CNT.
  - HDR_CNT: shift 2 bits into cnt; after 2nd → PAYLOAD. port_mask output updated from shadow on this transition.
  - PAYLOAD: each bit copied to ser_out.
    - bit_cnt (2 b) counts bits within a nibble; on bit_cnt wrap, lane increments.
    - After the last bit of nibble cnt → STOP.
  - STOP: line_in=1 → done pulse; line_in=0 → err pulse. Both → IDLE.
- A line 0 in the first IDLE cycle after STOP starts a new frame, so back-to-back frames work with no idle gap.
- Zero-length frames do not exist: CNT=0 means 1 nibble, CNT=3 means 4 nibbles.
- port_mask=0000: frame is fully parsed, ser_vld is forced low for the whole payload, lane still advances, and done/err behave as usual.
- port_mask and lane hold their last values in IDLE until the next frame's header completes. They are never cleared between frames.
- Reset values:
  - FSM = IDLE
  - ser_out=0, ser_vld=0, port_mask=0, lane=0, busy=0, done=0, err=0
  - internal counters = 0
- Reset mid-frame: immediate abort to IDLE with outputs at reset values. The partial frame is discarded and no done/err pulse is produced.

## Timing
- All outputs are registered.
- ser_out/ser_vld/lane appear one cycle after the corresponding payload bit is sampled.
- lane changes on the same edge as the first bit of the new nibble appears on ser_out.
- done/err assert in the cycle after the stop bit is sampled, concurrently with busy=0.
- busy rises the cycle after the start bit is sampled.
- busy falls the cycle after the stop bit is sampled.
- Frame length is 1+4+2+4(CNT+1)+1 cycles: 12 cycles minimum, 24 maximum.
- Payload latency: first payload bit on line_in at cycle 7 (start = cycle 0) appears on ser_out at cycle 8.

## Structure
- Package smb_pkg holds:
  - MASK_W=4, CNT_W=2, NIB_W=4
  - FSM state enum typedef smb_rx_state_t
- smb_pkg is shared with the switch so that port_mask/lane widths stay consistent.
- Single module; no sub-module is needed. The shift/count logic is small enough to stay inline.

## Test plan
- Reset, then idle line at 1 for 10 cycles → busy=0, ser_vld=0, all outputs 0.
- Frame PB=1100, CNT=00, payload 1010, stop 1:
  - port_mask=1100 from cycle 7
  - ser_out sequence 1,0,1,0 with ser_vld=1 on cycles 8–11, lane=0
  - done pulse at cycle 12
- Frame PB=1010, CNT=11, payload 16 bits 0x5A3C:
  - lane steps 0,1,2,3 every 4 valid bits
  - ser_out reproduces 0101 1010 0011 1100
  - done at cycle 24
- Same frame with stop bit 0 → err pulse, no done, FSM back in IDLE.
  - A 0 on the next cycle starts a new frame correctly.
- PB=0000, CNT=01 → ser_vld stays 0 for 8 payload cycles, lane goes 0→1, done pulses.
- Assert rst_n low during payload nibble 1 → outputs go to reset values immediately, no done/err.
  - A full frame sent after release is received correctly.

Source files
------------

// File: rtl/smb_pkg.sv
// Shared field widths and receiver state type for the serial multi-broadcast switch path.
package smb_pkg;

  localparam int unsigned MASK_W = 4;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned NIB_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    HDR_PB,
    HDR_CNT,
    PAYLOAD,
    STOP
  } smb_rx_state_t;

endpackage

// File: rtl/smb_frame_rx.sv
// Serial frame receiver: strips start/mask/count/stop fields and streams the payload
// bit-serially with its port mask and nibble lane, flagging bad stop bits.
module smb_frame_rx
  import smb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_in,
  output logic              ser_out,
  output logic              ser_vld,
  output logic [MASK_W-1:0] port_mask,
  output logic [CNT_W-1:0]  lane,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned BIT_W = $clog2(NIB_W);

  smb_rx_state_t     state_q;
  logic [MASK_W-1:0] shadow_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  nib_q;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic              ser_out_q;
  logic              ser_vld_q;
  logic [MASK_W-1:0] port_mask_q;
  logic [CNT_W-1:0]  lane_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      cnt_q       <= '0;
      nib_q       <= '0;
      bit_cnt_q   <= '0;
      ser_out_q   <= 1'b0;
      ser_vld_q   <= 1'b0;
      port_mask_q <= '0;
      lane_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ser_vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!line_in) begin
            state_q   <= HDR_PB;
            busy_q    <= 1'b1;
            bit_cnt_q <= '0;
          end
        end
        HDR_PB: begin
          shadow_q  <= {shadow_q[MASK_W-2:0], line_in};
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_W'(MASK_W - 1)) begin
            state_q   <= HDR_CNT;
            bit_cnt_q <= '0;
          end
        end
        HDR_CNT: begin
          cnt_q     <= {cnt_q[CNT_W-2:0], line_in};
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_W'(CNT_W - 1)) begin
            state_q     <= PAYLOAD;
            bit_cnt_q   <= '0;
            nib_q       <= '0;
            port_mask_q <= shadow_q;
            lane_q      <= '0;
          end
        end
        PAYLOAD: begin
          // Mask 0000 still walks the payload so lane and framing stay honest.
          ser_out_q <= line_in;
          ser_vld_q <= |port_mask_q;
          lane_q    <= nib_q;
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_W'(NIB_W - 1)) begin
            nib_q <= nib_q + 1'b1;
            if (nib_q == cnt_q) begin
              state_q <= STOP;
            end
          end
        end
        STOP: begin
          done_q  <= line_in;
          err_q   <= ~line_in;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ser_out   = ser_out_q;
  assign ser_vld   = ser_vld_q;
  assign port_mask = port_mask_q;
  assign lane      = lane_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_smb_frame_rx.sv
// Directed bench for smb_frame_rx: a per-cycle expectation timeline built from frame fields.
module tb_smb_frame_rx;
  import smb_pkg::*;

  localparam int MAXC = 1024;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              line_in = 1'b1;
  logic              ser_out, ser_vld, busy, done, err;
  logic [MASK_W-1:0] port_mask;
  logic [CNT_W-1:0]  lane;

  smb_frame_rx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .line_in  (line_in),
    .ser_out  (ser_out),
    .ser_vld  (ser_vld),
    .port_mask(port_mask),
    .lane     (lane),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expectation timeline, indexed by cycle (cycle k begins at the k-th rising edge).
  logic       exp_busy [MAXC];
  logic       exp_vld  [MAXC];
  logic       exp_out  [MAXC];
  logic       exp_done [MAXC];
  logic       exp_err  [MAXC];
  logic [3:0] exp_mask [MAXC];
  logic [1:0] exp_lane [MAXC];

  int n_total = 0;
  int n_pass  = 0;
  int f1_c0 = MAXC, f2_c0 = MAXC, f3_c0 = MAXC, f5_c0 = MAXC, rst_cyc = MAXC;

  initial begin
    for (int j = 0; j < MAXC; j++) begin
      exp_busy[j] = 1'b0; exp_vld[j] = 1'b0; exp_out[j] = 1'b0;
      exp_done[j] = 1'b0; exp_err[j] = 1'b0; exp_mask[j] = '0; exp_lane[j] = '0;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, expv);
  endtask

  always @(negedge clk) begin
    if (cyc < MAXC) begin
      chk("busy", {7'd0, busy}, {7'd0, exp_busy[cyc]});
      chk("ser_vld", {7'd0, ser_vld}, {7'd0, exp_vld[cyc]});
      chk("done", {7'd0, done}, {7'd0, exp_done[cyc]});
      chk("err", {7'd0, err}, {7'd0, exp_err[cyc]});
      chk("port_mask", {4'd0, port_mask}, {4'd0, exp_mask[cyc]});
      chk("lane", {6'd0, lane}, {6'd0, exp_lane[cyc]});
      if (exp_vld[cyc]) chk("ser_out", {7'd0, ser_out}, {7'd0, exp_out[cyc]});
    end
    // Hand-computed anchors that pin the timeline itself.
    if (cyc == 2) chk("reset_ser_out", {7'd0, ser_out}, 8'd0);
    if (cyc == f1_c0 + 7)  chk("f1_mask_c7", {4'd0, port_mask}, 8'h0C);
    if (cyc == f1_c0 + 8)  chk("f1_out_c8", {6'd0, ser_vld, ser_out}, 8'h03);
    if (cyc == f1_c0 + 9)  chk("f1_out_c9", {6'd0, ser_vld, ser_out}, 8'h02);
    if (cyc == f1_c0 + 11) chk("f1_out_c11", {6'd0, ser_vld, ser_out}, 8'h02);
    if (cyc == f1_c0 + 12) chk("f1_done_c12", {5'd0, busy, done, err}, 8'h02);
    if (cyc == f2_c0 + 20) chk("f2_lane_c20", {6'd0, lane}, 8'h03);
    if (cyc == f2_c0 + 24) chk("f2_done_c24", {5'd0, busy, done, err}, 8'h02);
    if (cyc == f3_c0 + 24) chk("f3_err_c24", {5'd0, busy, done, err}, 8'h01);
    if (cyc == f5_c0 + 12) chk("f5_lane_c12", {6'd0, lane, ser_vld}, 8'h02);
    if (cyc == rst_cyc)    chk("abort_outs", {busy, ser_vld, lane, port_mask}, 8'h00);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      line_in = 1'b1;
    end
  endtask

  task automatic apply_reset(input int r);
    for (int j = r; j < MAXC; j++) begin
      exp_busy[j] = 1'b0; exp_vld[j] = 1'b0; exp_done[j] = 1'b0;
      exp_err[j] = 1'b0; exp_mask[j] = '0; exp_lane[j] = '0;
    end
    rst_n   = 1'b0;
    line_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // abort_at > 0 replaces frame bit abort_at with a reset pulse.
  task automatic send_frame(input logic [3:0] pb, input logic [1:0] cnt,
                            input logic [15:0] payload, input logic stop,
                            input int abort_at, output int c0);
    int  n;
    int  len;
    logic fb [24];
    n   = 4 * (int'(cnt) + 1);
    len = 8 + n;
    fb[0] = 1'b0;
    for (int i = 0; i < 4; i++) fb[1 + i] = pb[3 - i];
    for (int i = 0; i < 2; i++) fb[5 + i] = cnt[1 - i];
    for (int k = 0; k < n; k++) fb[7 + k] = payload[n - 1 - k];
    fb[len - 1] = stop;
    c0 = 0;
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        c0 = cyc;
        for (int j = c0 + 1; j < c0 + len; j++) exp_busy[j] = 1'b1;
        for (int j = c0 + 7; j < MAXC; j++) exp_mask[j] = pb;
        exp_lane[c0 + 7] = 2'd0;
        for (int k = 0; k < n; k++) begin
          exp_lane[c0 + 8 + k] = 2'(k / 4);
          exp_vld[c0 + 8 + k]  = (pb != 4'd0);
          exp_out[c0 + 8 + k]  = fb[7 + k];
        end
        for (int j = c0 + 8 + n; j < MAXC; j++) exp_lane[j] = cnt;
        exp_done[c0 + len] = stop;
        exp_err[c0 + len]  = ~stop;
      end
      if (abort_at > 0 && i == abort_at) begin
        rst_cyc = cyc;
        apply_reset(cyc);
        return;
      end
      line_in = fb[i];
    end
  endtask

  initial begin
    int c;
    #100000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    line_in = 1'b1;
    rst_n   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(10);
    send_frame(4'b1100, 2'b00, 16'h000A, 1'b1, 0, c);  f1_c0 = c;
    idle(4);
    send_frame(4'b1010, 2'b11, 16'h5A3C, 1'b1, 0, c);  f2_c0 = c;
    idle(3);
    send_frame(4'b1010, 2'b11, 16'h5A3C, 1'b0, 0, c);  f3_c0 = c;
    send_frame(4'b0110, 2'b01, 16'h00C3, 1'b1, 0, c);
    send_frame(4'b0001, 2'b00, 16'h0009, 1'b1, 0, c);
    idle(2);
    send_frame(4'b0000, 2'b01, 16'h00FF, 1'b1, 0, c);  f5_c0 = c;
    idle(3);
    send_frame(4'b1111, 2'b10, 16'h09E1, 1'b1, 13, c);
    idle(4);
    send_frame(4'b0011, 2'b00, 16'h0006, 1'b1, 0, c);
    idle(6);
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
